// File: rtl/timer_mch_pkg.sv
// Shared register-map constants for the multi-channel timer.
// Offsets and CTRL bit positions are common to the top decode and each channel.
package timer_mch_pkg;

    localparam logic [3:0] TMR_OFF_CTRL  = 4'h0;
    localparam logic [3:0] TMR_OFF_COUNT = 4'h4;
    localparam logic [3:0] TMR_OFF_VALUE = 4'h8;
    localparam logic [3:0] TMR_STATUS_CH = 4'hF;

    localparam int TMR_CTRL_EN   = 0;
    localparam int TMR_CTRL_IE   = 1;
    localparam int TMR_CTRL_PEND = 2;
    localparam int TMR_CTRL_MODE = 3;
    localparam int TMR_PRE_LSB   = 8;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } tmr_mode_e;

endpackage

// File: rtl/timer_mch_if.sv
// Peripheral-bus view of the timer: single-cycle writes, combinational reads,
// plus the combined and per-channel interrupt outputs.
interface timer_mch_if #(
    parameter int NUM_CH = 4
);
    logic [31:0]       data_i;
    logic [31:0]       addr_i;
    logic              we_i;
    logic [31:0]       data_o;
    logic              int_sig_o;
    logic [NUM_CH-1:0] int_vec_o;

    modport master (
        output data_i, addr_i, we_i,
        input  data_o, int_sig_o, int_vec_o
    );

    modport slave (
        input  data_i, addr_i, we_i,
        output data_o, int_sig_o, int_vec_o
    );
endinterface

// File: rtl/timer_mch_chan.sv
// One timer channel: CTRL, COUNT, VALUE and the prescaler.
// Software writes take priority over hardware updates, except that an expiry always sets PEND.
module timer_mch_chan
    import timer_mch_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_ctrl,
    input  logic        we_count,
    input  logic        we_value,
    input  logic        status_clr,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_q,
    output logic [31:0] count_q,
    output logic [31:0] value_q,
    output logic        pend
);

    logic             en;
    logic             ie;
    tmr_mode_e        mode;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pcnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] value;

    logic tick;
    logic expire;
    logic pend_clr;
    logic unused_wdata;

    assign tick     = en && (pcnt == pre);
    // >= rather than == so a VALUE written below the running count still expires
    assign expire   = tick && (count >= value);
    assign pend_clr = (we_ctrl && wdata[TMR_CTRL_PEND]) || status_clr;
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en    <= 1'b0;
            ie    <= 1'b0;
            mode  <= MODE_ONESHOT;
            pre   <= '0;
            pcnt  <= '0;
            count <= '0;
            value <= '0;
            pend  <= 1'b0;
        end else begin
            if (we_ctrl) begin
                en   <= wdata[TMR_CTRL_EN];
                ie   <= wdata[TMR_CTRL_IE];
                mode <= tmr_mode_e'(wdata[TMR_CTRL_MODE]);
                pre  <= wdata[TMR_PRE_LSB +: PRE_W];
            end else if (expire && mode == MODE_ONESHOT) begin
                en <= 1'b0;
            end

            if (expire) begin
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            if (we_value) begin
                value <= wdata[CNT_W-1:0];
            end

            if (we_count) begin
                count <= wdata[CNT_W-1:0];
                pcnt  <= '0;
            end else if (!en) begin
                count <= '0;
                pcnt  <= '0;
            end else begin
                pcnt <= tick ? '0 : pcnt + PRE_W'(1);
                if (tick) begin
                    count <= expire ? '0 : count + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ctrl_q = '0;
        ctrl_q[TMR_CTRL_EN]   = en;
        ctrl_q[TMR_CTRL_IE]   = ie;
        ctrl_q[TMR_CTRL_PEND] = pend;
        ctrl_q[TMR_CTRL_MODE] = mode;
        ctrl_q[TMR_PRE_LSB +: PRE_W] = pre;
    end

    assign count_q = 32'(count);
    assign value_q = 32'(value);

endmodule

// File: rtl/timer_mch.sv
// Multi-channel memory-mapped timer: address decode, read mux, STATUS assembly
// and interrupt combining around NUM_CH independent channels.
module timer_mch
    import timer_mch_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    timer_mch_if.slave  bus
);

    logic [3:0]        ch;
    logic [3:0]        off;
    logic              status_we;
    logic [NUM_CH-1:0] status_clr;
    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] ie_vec;
    logic [NUM_CH-1:0] int_vec;
    logic [31:0]       ctrl_v  [NUM_CH];
    logic [31:0]       count_v [NUM_CH];
    logic [31:0]       value_v [NUM_CH];
    logic [31:0]       rdata;
    logic              unused_addr;

    assign ch  = bus.addr_i[7:4];
    assign off = bus.addr_i[3:0];
    assign unused_addr = ^bus.addr_i[31:8];

    assign status_we  = bus.we_i && (ch == TMR_STATUS_CH) && (off == TMR_OFF_CTRL);
    assign status_clr = status_we ? bus.data_i[NUM_CH-1:0] : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = bus.we_i && (ch == 4'(i));

        timer_mch_chan #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .we_ctrl    (sel && (off == TMR_OFF_CTRL)),
            .we_count   (sel && (off == TMR_OFF_COUNT)),
            .we_value   (sel && (off == TMR_OFF_VALUE)),
            .status_clr (status_clr[i]),
            .wdata      (bus.data_i),
            .ctrl_q     (ctrl_v[i]),
            .count_q    (count_v[i]),
            .value_q    (value_v[i]),
            .pend       (pend_vec[i])
        );

        assign ie_vec[i] = ctrl_v[i][TMR_CTRL_IE];
    end

    assign int_vec       = pend_vec & ie_vec;
    assign bus.int_vec_o = int_vec;
    assign bus.int_sig_o = |int_vec;

    // Unmapped channels and the reserved offset fall through to zero
    always_comb begin
        rdata = '0;
        if (ch == TMR_STATUS_CH) begin
            if (off == TMR_OFF_CTRL) begin
                rdata = 32'(pend_vec);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch == 4'(i)) begin
                    case (off)
                        TMR_OFF_CTRL:  rdata = ctrl_v[i];
                        TMR_OFF_COUNT: rdata = count_v[i];
                        TMR_OFF_VALUE: rdata = value_v[i];
                        default:       rdata = '0;
                    endcase
                end
            end
        end
    end

    assign bus.data_o = rdata;

endmodule
